// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding instruction fetch stage. Issues word
//                requests to instruction memory, holds the fetched word for
//                decode, and squashes in-flight work on branch/jump redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch_en,
    input  logic        branch_sel,
    input  logic        jump_en,
    input  logic [31:0] target_addr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        capture;

    // Byte-offset bit 0 never affects a word fetch address.
    wire unused_target_bit0 = target_addr[0];

    assign redirect    = (branch_en & branch_sel) | jump_en;
    assign redirect_pc = {target_addr[31:2], 2'b00};
    // A response is accepted into the decode buffer only in WAIT without a squash.
    assign capture     = (state == WAIT) && imem_rsp_valid && !redirect;

    // Requests are only presented from FETCH, and never while in reset.
    assign imem_req_valid = (state == FETCH) && !rst;
    assign imem_req_addr  = pc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a redirect overrides every other event.
    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (redirect) begin
                    // An accepted request still owes a response that must be eaten.
                    next_state = imem_req_ready ? DROP : FETCH;
                end else if (imem_req_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    next_state = imem_rsp_valid ? FETCH : DROP;
                end else if (imem_rsp_valid) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (redirect || if_ready) begin
                    next_state = FETCH;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    // Program counter: load redirect target, or advance once a word is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (capture) begin
            pc <= pc + 32'd4;
        end
    end

    // Decode-side buffer: capture on response, release on handshake or squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
        end else if (redirect) begin
            if_valid <= 1'b0;
        end else if (capture) begin
            if_valid <= 1'b1;
            if_instr <= imem_rsp_data;
            if_pc    <= pc;
        end else if (state == HOLD && if_ready) begin
            if_valid <= 1'b0;
        end
    end

    // Misaligned-target flag, one cycle after the offending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect & target_addr[1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with a
//                scoreboard of expected (pc, instr) deliveries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        branch_en;
    logic        branch_sel;
    logic        jump_en;
    logic [31:0] target_addr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int deliv_cyc = 0;
    int prev_cyc  = 0;
    logic [63:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch_en      (branch_en),
        .branch_sel     (branch_sel),
        .jump_en        (jump_en),
        .target_addr    (target_addr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, and accept it.
    task automatic issue(input logic [31:0] addr);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] addr, input logic [31:0] data, input bit deliver);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        if (deliver) exp_q.push_back({addr, data});
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    // Compare the held instruction against the scoreboard head.
    task automatic deliver();
        logic [63:0] e;
        check("if_valid", {31'b0, if_valid}, 32'd1);
        tests++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=%0d expected=nonzero", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("if_pc", if_pc, e[63:32]);
            check("if_instr", if_instr, e[31:0]);
        end
        prev_cyc  = deliv_cyc;
        deliv_cyc = cyc;
    endtask

    task automatic accept();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
    endtask

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        issue(addr);
        respond(addr, data, 1'b1);
        deliver();
        accept();
    endtask

    task automatic redirect_jump(input logic [31:0] tgt);
        jump_en     = 1'b1;
        target_addr = tgt;
        tick();
        jump_en     = 1'b0;
        target_addr = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        branch_en = 1'b0;
        branch_sel = 1'b0;
        jump_en = 1'b0;
        target_addr = 32'h0;
        if_ready = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0);

        // Back-to-back stream, one instruction every 3 cycles
        fetch_one(32'h0, 32'h0000_0013);
        fetch_one(32'h4, 32'h0000_0013);
        check("stream_period", deliv_cyc - prev_cyc, 32'd3);
        fetch_one(32'h8, 32'h0000_0013);
        check("stream_period2", deliv_cyc - prev_cyc, 32'd3);

        // Decode stall for 5 cycles in HOLD
        issue(32'hC);
        respond(32'hC, 32'h00A0_0093, 1'b1);
        deliver();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_if_pc", if_pc, 32'hC);
            check("stall_if_instr", if_instr, 32'h00A0_0093);
            check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        accept();
        check("after_stall_addr", imem_req_addr, 32'h10);

        // Taken branch while waiting; late response must be discarded
        issue(32'h10);
        branch_en = 1'b1; branch_sel = 1'b1; target_addr = 32'h100;
        tick();
        branch_en = 1'b0; branch_sel = 1'b0; target_addr = 32'h0;
        check("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
        check("drop_if_valid", {31'b0, if_valid}, 32'd0);
        respond(32'h10, 32'hDEAD_BEEF, 1'b0);
        check("post_drop_if_valid", {31'b0, if_valid}, 32'd0);
        fetch_one(32'h100, 32'h1111_1111);

        // Not-taken branch in HOLD has no effect
        issue(32'h104);
        respond(32'h104, 32'h2222_2222, 1'b1);
        branch_en = 1'b1; branch_sel = 1'b0; target_addr = 32'h300;
        tick();
        branch_en = 1'b0; target_addr = 32'h0;
        deliver();
        accept();
        check("nottaken_next", imem_req_addr, 32'h108);

        // Misaligned jump squashes the held instruction
        issue(32'h108);
        respond(32'h108, 32'h3333_3333, 1'b0);
        redirect_jump(32'h202);
        check("hold_squash_valid", {31'b0, if_valid}, 32'd0);
        check("misalign_pulse", {31'b0, misalign_err}, 32'd1);
        check("misalign_addr", imem_req_addr, 32'h200);
        tick();
        check("misalign_clear", {31'b0, misalign_err}, 32'd0);

        // Redirect in FETCH without acceptance: stay in FETCH at new pc
        redirect_jump(32'h400);
        check("fetch_redir_valid", {31'b0, imem_req_valid}, 32'd1);
        check("fetch_redir_addr", imem_req_addr, 32'h400);
        check("aligned_no_err", {31'b0, misalign_err}, 32'd0);

        // Redirect with acceptance -> DROP; redirect again while dropping
        imem_req_ready = 1'b1;
        redirect_jump(32'h500);
        imem_req_ready = 1'b0;
        check("accept_redir_drop", {31'b0, imem_req_valid}, 32'd0);
        redirect_jump(32'h600);
        check("drop_redir_stay", {31'b0, imem_req_valid}, 32'd0);
        respond(32'h0, 32'h4444_4444, 1'b0);
        fetch_one(32'h600, 32'h5555_5555);

        // Redirect coincident with the response in WAIT
        issue(32'h604);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h6666_6666;
        redirect_jump(32'h700);
        imem_rsp_valid = 1'b0;
        check("wait_rsp_redir_valid", {31'b0, if_valid}, 32'd0);
        check("wait_rsp_redir_addr", imem_req_addr, 32'h700);

        // PC wrap at the top of the address space
        redirect_jump(32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h7777_7777);
        check("wrap_addr", imem_req_addr, 32'h0);
        fetch_one(32'h0, 32'h8888_8888);

        // Reset while a request is outstanding
        issue(32'h4);
        rst = 1'b1;
        tick();
        check("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_req_addr", imem_req_addr, 32'h0);

        // Stray response in FETCH is ignored
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h9999_9999;
        tick();
        imem_rsp_valid = 1'b0;
        check("stray_if_valid", {31'b0, if_valid}, 32'd0);
        fetch_one(32'h0, 32'hAAAA_AAAA);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
